// File: rtl/pipe_dff_reg_if.sv
// Data bus of a pipeline stage latch: the upstream stage drives d, the
// downstream stage reads q.
interface pipe_dff_reg_if #(
  parameter int WIDTH = 64
);
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;

  modport master (output d, input  q);
  modport slave  (input  d, output q);
endinterface

// File: rtl/pipe_dff_reg.sv
// Width-parameterised pipeline latch: captures d on every rising clk edge.
// A synchronous active-high reset clears it. Each bit is an independent flop.
module pipe_dff_bit (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);
  logic q_q, q_d;

  always_comb q_d = reset ? 1'b0 : d_i;

  always_ff @(posedge clk) q_q <= q_d;

  assign q_o = q_q;
endmodule

module pipe_dff_reg #(
  parameter int WIDTH = 64
) (
  input  logic              clk,
  input  logic              reset,
  pipe_dff_reg_if.slave     bus
);
  logic [WIDTH-1:0] q_w;

  // One flop per bit, so bit i of q depends only on bit i of d.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pipe_dff_bit u_bit (
      .clk   (clk),
      .reset (reset),
      .d_i   (bus.d[i]),
      .q_o   (q_w[i])
    );
  end

  assign bus.q = q_w;
endmodule

// File: tb/tb_pipe_dff_reg.sv
// Bench for pipe_dff_reg at WIDTH 5, 32 and 64 side by side; edge results are
// checked from a scoreboard queue, between-edge stability is checked directly.
module tb_pipe_dff_reg;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  pipe_dff_reg_if #(.WIDTH(5))  if5  ();
  pipe_dff_reg_if #(.WIDTH(32)) if32 ();
  pipe_dff_reg_if #(.WIDTH(64)) if64 ();

  pipe_dff_reg #(.WIDTH(5))  u5  (.clk(clk), .reset(reset), .bus(if5));
  pipe_dff_reg #(.WIDTH(32)) u32 (.clk(clk), .reset(reset), .bus(if32));
  pipe_dff_reg #(.WIDTH(64)) u64 (.clk(clk), .reset(reset), .bus(if64));

  always #10 clk = ~clk;

  typedef struct {
    logic [4:0]  e5;
    logic [31:0] e32;
    logic [63:0] e64;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // Drive all three latches at the negedge, record the expected capture,
  // then return just after the next rising edge.
  task automatic step(input logic [63:0] v, input logic rst);
    exp_t e;
    @(negedge clk);
    if64.d = v;
    if32.d = v[31:0];
    if5.d  = v[4:0];
    reset  = rst;
    e.e64  = rst ? 64'h0 : v;
    e.e32  = rst ? 32'h0 : v[31:0];
    e.e5   = rst ? 5'h0  : v[4:0];
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("q5",  {59'h0, if5.q},  {59'h0, mon_e.e5});
      chk("q32", {32'h0, if32.q}, {32'h0, mon_e.e32});
      chk("q64", if64.q, mon_e.e64);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] v;
    if5.d = '0; if32.d = '0; if64.d = '0;

    // Reset with all-ones on d, then release with d unchanged
    step(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    step(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    step(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);

    // One-edge latency and stability between edges
    step(64'h0000_0000_8B1F_03E0, 1'b0);
    #8 chk("hold32_a", {32'h0, if32.q}, 64'h8B1F_03E0);
    step(64'h0000_0000_9100_0421, 1'b0);
    #8 chk("hold32_b", {32'h0, if32.q}, 64'h9100_0421);
    step(64'h0000_0000_B400_0040, 1'b0);
    #8 chk("hold32_c", {32'h0, if32.q}, 64'hB400_0040);

    // d glitches between edges are ignored
    step(64'd30, 1'b0);
    #2 if5.d = 5'd0;
    #2 if5.d = 5'd31;
    #2 if5.d = 5'd0;
    #2 chk("glitch5", {59'h0, if5.q}, 64'd30);
    step(64'd17, 1'b0);

    // Reset pulsed entirely between edges has no effect
    step(64'h0000_0000_0000_1234, 1'b0);
    #3 reset = 1'b1;
    #3 reset = 1'b0;
    #2 chk("rstpulse64", if64.q, 64'h1234);
    chk("rstpulse32", {32'h0, if32.q}, 64'h1234);
    step(64'h0000_0000_0000_1234, 1'b1);
    step(64'hDEAD_BEEF_CAFE_F00D, 1'b0);

    // Walking one then walking zero
    for (int i = 0; i < 64; i++) begin
      v = 64'h1 << i;
      step(v, 1'b0);
    end
    for (int i = 0; i < 64; i++) begin
      v = ~(64'h1 << i);
      step(v, 1'b0);
    end

    // All-ones on every width, then a reset edge clears all three
    step(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    step(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    step(64'h0123_4567_89AB_CDEF, 1'b0);

    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #2 chk("drain", 64'(exp_q.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
